// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU/multiplier issue and writeback sequencer.
// The multiplier command type is also used by decode.
package alu_seq_pkg;

    localparam int MUL_EN_BIT = 3;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL_WAIT,
        WB_LO,
        WB_HI
    } alu_seq_state_t;

    typedef logic [2:0] mul_cmd_t;

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter with a zero flag.
// Used to time multiplier occupancy.
module latency_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the ALU/multiplier execute block.
// Long multiplies write the low word first, then the high word.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int RA_W        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [3:0]      issue_mul_ctl,
    input  logic            issue_long,
    input  logic            issue_set_flags,
    input  logic [RA_W-1:0] issue_rd_lo,
    input  logic [RA_W-1:0] issue_rd_hi,
    input  logic [31:0]     out1,
    input  logic [31:0]     out2,
    input  logic [3:0]      cond_flags,
    output logic [3:0]      mul_ctl,
    output logic            wb_valid,
    output logic [RA_W-1:0] wb_addr,
    output logic [31:0]     wb_data,
    input  logic            wb_ready,
    output logic            flags_we,
    output logic [3:0]      flags,
    output logic            busy
);

    localparam int CW = $clog2(MUL_LATENCY + 1);

    alu_seq_state_t  state_q, state_d;
    logic [3:0]      mul_ctl_q, mul_ctl_d;
    logic [RA_W-1:0] rd_lo_q, rd_lo_d;
    logic [RA_W-1:0] rd_hi_q, rd_hi_d;
    logic            long_q, long_d;
    logic            set_flags_q, set_flags_d;
    logic [31:0]     hi_data_q, hi_data_d;
    logic            wb_valid_q, wb_valid_d;
    logic [RA_W-1:0] wb_addr_q, wb_addr_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            flags_we_q, flags_we_d;
    logic [3:0]      flags_q, flags_d;

    logic     cnt_load;
    logic     cnt_dec;
    logic     cnt_zero;
    logic     capture;
    logic     is_mul;
    mul_cmd_t cmd;

    assign is_mul = issue_mul_ctl[MUL_EN_BIT];
    assign cmd    = mul_cmd_t'(issue_mul_ctl[2:0]);

    latency_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (CW'(MUL_LATENCY - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        mul_ctl_d   = mul_ctl_q;
        rd_lo_d     = rd_lo_q;
        rd_hi_d     = rd_hi_q;
        long_d      = long_q;
        set_flags_d = set_flags_q;
        hi_data_d   = hi_data_q;
        wb_valid_d  = wb_valid_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        flags_d     = flags_q;
        flags_we_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        capture     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    mul_ctl_d   = {is_mul, cmd};
                    rd_lo_d     = issue_rd_lo;
                    rd_hi_d     = issue_rd_hi;
                    long_d      = issue_long & is_mul;
                    set_flags_d = issue_set_flags;
                    state_d     = is_mul ? MUL_WAIT : EXEC;
                    cnt_load    = is_mul;
                end
            end
            EXEC: capture = 1'b1;
            MUL_WAIT: begin
                capture = cnt_zero;
                cnt_dec = !cnt_zero;
            end
            WB_LO: begin
                if (wb_ready) begin
                    if (long_q) begin
                        state_d   = WB_HI;
                        wb_addr_d = rd_hi_q;
                        wb_data_d = hi_data_q;
                    end else begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b0;
                        mul_ctl_d  = '0;
                    end
                end
            end
            WB_HI: begin
                if (wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                    mul_ctl_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Low word goes out first; the high word waits in hi_data.
        if (capture) begin
            state_d    = WB_LO;
            wb_valid_d = 1'b1;
            wb_addr_d  = rd_lo_q;
            wb_data_d  = long_q ? out2 : out1;
            hi_data_d  = out1;
            flags_d    = cond_flags;
            flags_we_d = set_flags_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mul_ctl_q   <= '0;
            rd_lo_q     <= '0;
            rd_hi_q     <= '0;
            long_q      <= 1'b0;
            set_flags_q <= 1'b0;
            hi_data_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            flags_we_q  <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            mul_ctl_q   <= mul_ctl_d;
            rd_lo_q     <= rd_lo_d;
            rd_hi_q     <= rd_hi_d;
            long_q      <= long_d;
            set_flags_q <= set_flags_d;
            hi_data_q   <= hi_data_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            flags_we_q  <= flags_we_d;
            flags_q     <= flags_d;
        end
    end

    assign issue_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mul_ctl     = mul_ctl_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign flags_we    = flags_we_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed ops, writes checked
// by a negedge monitor, cycle timing checked by the stimulus thread.
module tb_alu_sequencer;

    localparam int RA_W = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            issue_valid;
    logic            issue_ready;
    logic [3:0]      issue_mul_ctl;
    logic            issue_long;
    logic            issue_set_flags;
    logic [RA_W-1:0] issue_rd_lo;
    logic [RA_W-1:0] issue_rd_hi;
    logic [31:0]     out1;
    logic [31:0]     out2;
    logic [3:0]      cond_flags;
    logic [3:0]      mul_ctl;
    logic            wb_valid;
    logic [RA_W-1:0] wb_addr;
    logic [31:0]     wb_data;
    logic            wb_ready;
    logic            flags_we;
    logic [3:0]      flags;
    logic            busy;

    typedef struct packed {
        logic [RA_W-1:0] a;
        logic [31:0]     d;
    } wb_t;

    wb_t        wbq[$];
    logic [3:0] flq[$];
    int checks = 0;
    int errors = 0;
    int wb_seen = 0;
    int fl_seen = 0;

    alu_sequencer #(.MUL_LATENCY(3), .RA_W(RA_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_mul_ctl   (issue_mul_ctl),
        .issue_long      (issue_long),
        .issue_set_flags (issue_set_flags),
        .issue_rd_lo     (issue_rd_lo),
        .issue_rd_hi     (issue_rd_hi),
        .out1            (out1),
        .out2            (out2),
        .cond_flags      (cond_flags),
        .mul_ctl         (mul_ctl),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .wb_ready        (wb_ready),
        .flags_we        (flags_we),
        .flags           (flags),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write and every flag strobe is scored.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wb_valid && wb_ready) begin
                wb_seen++;
                if (wbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got %h=%h expected none",
                             wb_addr, wb_data);
                end else begin
                    wb_t e;
                    e = wbq.pop_front();
                    chk("wb_addr", 32'(wb_addr), 32'(e.a));
                    chk("wb_data", wb_data, e.d);
                end
            end
            if (flags_we) begin
                fl_seen++;
                if (flq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flags_unexpected: got %h expected none",
                             flags);
                end else begin
                    logic [3:0] f;
                    f = flq.pop_front();
                    chk("flags", 32'(flags), 32'(f));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!issue_ready && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(issue_ready), 32'd1);
    endtask

    task automatic issue(input logic [3:0] ctl, input logic lng,
                         input logic sf, input logic [RA_W-1:0] lo,
                         input logic [RA_W-1:0] hi, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [3:0] cf);
        issue_valid     = 1'b1;
        issue_mul_ctl   = ctl;
        issue_long      = lng;
        issue_set_flags = sf;
        issue_rd_lo     = lo;
        issue_rd_hi     = hi;
        out1            = o1;
        out2            = o2;
        cond_flags      = cf;
    endtask

    initial begin
        int fl0;
        int wb0;
        logic rose;
        reset_n = 1'b0;
        issue_valid = 1'b0;
        issue_mul_ctl = '0;
        issue_long = 1'b0;
        issue_set_flags = 1'b0;
        issue_rd_lo = '0;
        issue_rd_hi = '0;
        out1 = '0;
        out2 = '0;
        cond_flags = '0;
        wb_ready = 1'b1;
        step();
        step();
        reset_n = 1'b1;

        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_ctl", 32'(mul_ctl), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_flags_we", 32'(flags_we), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);

        // ALU op with flags.
        step();
        issue(4'b0000, 1'b0, 1'b1, 4'd5, 4'd0, 32'hFF, 32'h0, 4'b0010);
        wbq.push_back('{a: 4'd5, d: 32'hFF});
        flq.push_back(4'b0010);
        step();
        issue_valid = 1'b0;
        chk("alu_busy_c1", 32'(busy), 32'd1);
        step();
        chk("alu_wb_valid_c2", 32'(wb_valid), 32'd1);
        chk("alu_wb_addr_c2", 32'(wb_addr), 32'd5);
        chk("alu_wb_data_c2", wb_data, 32'hFF);
        chk("alu_flags_we_c2", 32'(flags_we), 32'd1);
        chk("alu_flags_c2", 32'(flags), 32'b0010);
        step();
        chk("alu_ready_c3", 32'(issue_ready), 32'd1);
        chk("alu_flags_we_c3", 32'(flags_we), 32'd0);

        // Long multiply, L=3.
        issue(4'b1010, 1'b1, 1'b0, 4'd2, 4'd3, 32'h1234_5678,
              32'h9ABC_DEF0, 4'b0000);
        wbq.push_back('{a: 4'd2, d: 32'h9ABC_DEF0});
        wbq.push_back('{a: 4'd3, d: 32'h1234_5678});
        step();
        issue_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 5) chk("lm_mul_ctl", 32'(mul_ctl), 32'hA);
            if (c == 4) begin
                chk("lm_lo_valid", 32'(wb_valid), 32'd1);
                chk("lm_lo_addr", 32'(wb_addr), 32'd2);
                chk("lm_lo_data", wb_data, 32'h9ABC_DEF0);
            end
            if (c == 5) begin
                chk("lm_hi_addr", 32'(wb_addr), 32'd3);
                chk("lm_hi_data", wb_data, 32'h1234_5678);
            end
            if (c == 6) begin
                chk("lm_ready_c6", 32'(issue_ready), 32'd1);
                chk("lm_mul_ctl_c6", 32'(mul_ctl), 32'd0);
            end
            if (c < 6) step();
        end

        // Reset while in MUL_WAIT.
        wb0 = wb_seen;
        issue(4'b1001, 1'b1, 1'b1, 4'd1, 4'd2, 32'h1, 32'h2, 4'b1111);
        step();
        issue_valid = 1'b0;
        step();
        chk("rst_mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(issue_ready), 32'd1);
        chk("rst_mid_mul_ctl", 32'(mul_ctl), 32'd0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        step();
        reset_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (wb_valid) rose = 1'b1;
            step();
        end
        chk("rst_mid_no_wb", 32'(rose), 32'd0);
        chk("rst_mid_wb_count", 32'(wb_seen - wb0), 32'd0);
        chk("rst_mid_idle", 32'(issue_ready), 32'd1);

        // Backpressure during WB_LO of a long multiply.
        fl0 = fl_seen;
        issue(4'b1100, 1'b1, 1'b1, 4'd4, 4'd9, 32'hAAAA_0001,
              32'hBBBB_0002, 4'b1001);
        wbq.push_back('{a: 4'd4, d: 32'hBBBB_0002});
        wbq.push_back('{a: 4'd9, d: 32'hAAAA_0001});
        flq.push_back(4'b1001);
        step();
        issue_valid = 1'b0;
        step();
        step();
        step();
        wb_ready = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            if (c == 7) wb_ready = 1'b1;
            chk("bp_lo_valid", 32'(wb_valid), 32'd1);
            chk("bp_lo_addr", 32'(wb_addr), 32'd4);
            chk("bp_lo_data", wb_data, 32'hBBBB_0002);
            step();
        end
        chk("bp_hi_addr_c8", 32'(wb_addr), 32'd9);
        chk("bp_hi_data_c8", wb_data, 32'hAAAA_0001);
        step();
        chk("bp_ready_c9", 32'(issue_ready), 32'd1);
        chk("bp_flag_pulses", 32'(fl_seen - fl0), 32'd1);

        // Back-to-back ALU ops with issue_valid held; long is ignored.
        wb0 = wb_seen;
        issue(4'b0000, 1'b1, 1'b0, 4'd10, 4'd15, 32'h100, 32'hDEAD, 4'b0);
        wbq.push_back('{a: 4'd10, d: 32'h100});
        for (int i = 0; i < 4; i++) begin
            chk("b2b_accept", 32'(issue_ready), 32'd1);
            step();
            chk("b2b_hold1", 32'(issue_ready), 32'd0);
            step();
            chk("b2b_hold2", 32'(issue_ready), 32'd0);
            if (i < 3) begin
                issue_rd_lo = RA_W'(11 + i);
                out1 = 32'h101 + 32'(i);
                wbq.push_back('{a: RA_W'(11 + i), d: 32'h101 + 32'(i)});
            end else begin
                issue_valid = 1'b0;
            end
            step();
        end
        wait_idle();
        chk("b2b_wb_count", 32'(wb_seen - wb0), 32'd4);

        // Long multiply with rd_lo == rd_hi: high word must land last.
        issue(4'b1011, 1'b1, 1'b0, 4'd7, 4'd7, 32'hCAFE_BABE,
              32'hDEAD_BEEF, 4'b0);
        wbq.push_back('{a: 4'd7, d: 32'hDEAD_BEEF});
        wbq.push_back('{a: 4'd7, d: 32'hCAFE_BABE});
        step();
        issue_valid = 1'b0;
        wait_idle();
        step();

        chk("wbq_drained", 32'(wbq.size()), 32'd0);
        chk("flq_drained", 32'(flq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
